// File: rtl/bvh_prim_dispatcher_if.sv
// Primitive dispatch stream between the dispatcher and the intersection unit.
// Handshake: the master raises prim_valid with prim_index/prim_last and holds
// all three stable until a cycle where prim_ready is also high; that cycle is
// the transfer (prim_valid & prim_ready). prim_ready may toggle freely and has
// no effect while prim_valid is low.
interface bvh_prim_dispatcher_if #(
  parameter int IDX_W = 16
);
  logic             prim_valid;
  logic [IDX_W-1:0] prim_index;
  logic             prim_last;
  logic             prim_ready;

  modport master (
    output prim_valid,
    output prim_index,
    output prim_last,
    input  prim_ready
  );

  modport slave (
    input  prim_valid,
    input  prim_index,
    input  prim_last,
    output prim_ready
  );
endinterface

// File: rtl/bvh_prim_dispatcher.sv
// BVH leaf primitive dispatcher: queues up to two leaf ranges per cycle from
// the traversal unit and expands each range into one primitive index per
// accepted transfer on the dispatch stream.
module bvh_prim_dispatcher #(
  parameter int IDX_W = 16,
  parameter int CNT_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  restart_strobe,
  input  logic [IDX_W-1:0]      start_prim [2],
  input  logic [CNT_W-1:0]      num_prim   [2],
  input  logic                  bvh_finished,
  output logic                  stall,
  bvh_prim_dispatcher_if.master prim_if,
  output logic                  overflow,
  output logic                  done,
  output logic                  o_dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = PTR_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [IDX_W-1:0] r_fifo_start [DEPTH];
  logic [CNT_W-1:0] r_fifo_num   [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic [IDX_W-1:0] r_cur;
  logic [CNT_W-1:0] r_rem;
  logic             r_last;
  logic             r_overflow;
  logic             r_done;

  logic             w_v0;
  logic             w_v1;
  logic [CW-1:0]    w_free;
  logic             w_push0;
  logic             w_push1;
  logic             w_drop;
  logic [PTR_W-1:0] w_wr_idx1;
  logic             w_pop;
  logic             w_advance;
  logic [IDX_W-1:0] w_head_start;
  logic [CNT_W-1:0] w_head_num;

  assign w_v0         = (num_prim[0] != '0);
  assign w_v1         = (num_prim[1] != '0);
  assign w_free       = CW'(DEPTH) - r_count;
  assign w_wr_idx1    = r_wr_ptr + PTR_W'(w_push0);
  assign w_head_start = r_fifo_start[r_rd_ptr];
  assign w_head_num   = r_fifo_num[r_rd_ptr];

  // Admission: lane 0 has priority for the free slots; anything that does
  // not fit is dropped and flagged. Free space ignores a same-cycle pop so
  // the decision never depends on the consumer handshake.
  always_comb begin
    w_push0 = 1'b0;
    w_push1 = 1'b0;
    w_drop  = 1'b0;
    if (!restart_strobe) begin
      if (w_v0 && w_v1) begin
        if (w_free >= CW'(2)) begin
          w_push0 = 1'b1;
          w_push1 = 1'b1;
        end else if (w_free == CW'(1)) begin
          w_push0 = 1'b1;
          w_drop  = 1'b1;
        end else begin
          w_drop  = 1'b1;
        end
      end else if (w_v0) begin
        if (w_free != '0) w_push0 = 1'b1;
        else              w_drop  = 1'b1;
      end else if (w_v1) begin
        if (w_free != '0) w_push1 = 1'b1;
        else              w_drop  = 1'b1;
      end
    end
  end

  // FSM next state and range pop/advance controls; restart overrides all.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_next_state = S_EMIT;
        end
      end
      S_EMIT: begin
        if (prim_if.prim_ready) begin
          if (r_last) begin
            // Chain straight into the next queued range with no bubble.
            if (r_count != '0) w_pop        = 1'b1;
            else               w_next_state = S_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (restart_strobe) begin
      w_next_state = S_IDLE;
      w_pop        = 1'b0;
      w_advance    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Range FIFO pointers and occupancy: count + pushes - pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (restart_strobe) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push0) + PTR_W'(w_push1);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
    end
  end

  // Range FIFO storage; lane 1 lands behind lane 0 when both are admitted.
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_fifo_start[r_wr_ptr] <= start_prim[0];
      r_fifo_num[r_wr_ptr]   <= num_prim[0];
    end
    if (w_push1) begin
      r_fifo_start[w_wr_idx1] <= start_prim[1];
      r_fifo_num[w_wr_idx1]   <= num_prim[1];
    end
  end

  // Current range walker: load on pop, step on a non-final transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cur  <= '0;
      r_rem  <= '0;
      r_last <= 1'b0;
    end else if (w_pop) begin
      r_cur  <= w_head_start;
      r_rem  <= w_head_num;
      r_last <= (w_head_num == CNT_W'(1));
    end else if (w_advance) begin
      r_cur  <= r_cur + IDX_W'(1);
      r_rem  <= r_rem - CNT_W'(1);
      r_last <= (r_rem == CNT_W'(2));
    end else if (w_next_state == S_IDLE) begin
      r_last <= 1'b0;
    end
  end

  // Sticky overflow flag and registered completion flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
      r_done     <= 1'b1;
    end else if (restart_strobe) begin
      r_overflow <= 1'b0;
      r_done     <= bvh_finished;
    end else begin
      r_overflow <= r_overflow | w_drop;
      r_done     <= bvh_finished && (r_count == '0) && (r_state == S_IDLE) &&
                    !w_push0 && !w_push1;
    end
  end

  assign prim_if.prim_valid = (r_state == S_EMIT);
  assign prim_if.prim_index = r_cur;
  assign prim_if.prim_last  = r_last;
  assign stall              = (r_count > CW'(DEPTH - 2));
  assign overflow           = r_overflow;
  assign done               = r_done;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_bvh_prim_dispatcher.sv
// Directed bench for bvh_prim_dispatcher: each task drives one scenario and
// compares the dispatch stream and flags against hand-computed values.
module tb_bvh_prim_dispatcher;

  logic        clk;
  logic        resetn;
  logic        restart_strobe;
  logic [15:0] start_prim [2];
  logic [3:0]  num_prim   [2];
  logic        bvh_finished;
  logic        stall;
  logic        overflow;
  logic        done;
  logic        dbg_state;

  int          n_checks;
  int          n_errors;
  logic [15:0] exp_q[$];
  logic [15:0] exp_idx;

  bvh_prim_dispatcher_if #(.IDX_W(16)) prim_if ();

  bvh_prim_dispatcher #(.IDX_W(16), .CNT_W(4), .DEPTH(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .restart_strobe (restart_strobe),
    .start_prim     (start_prim),
    .num_prim       (num_prim),
    .bvh_finished   (bvh_finished),
    .stall          (stall),
    .prim_if        (prim_if),
    .overflow       (overflow),
    .done           (done),
    .o_dbg_state    (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  task automatic clear_lanes();
    start_prim[0] = '0;
    start_prim[1] = '0;
    num_prim[0]   = '0;
    num_prim[1]   = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    restart_strobe = 1'b0;
    bvh_finished = 1'b0;
    prim_if.prim_ready = 1'b1;
    clear_lanes();
    repeat (2) @(negedge clk);
    n_checks++; if (prim_if.prim_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", prim_if.prim_valid); end
    n_checks++; if (prim_if.prim_index !== 16'h0000) begin n_errors++; $display("FAIL reset_index: got %h expected 0000", prim_if.prim_index); end
    n_checks++; if (prim_if.prim_last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b expected 0", prim_if.prim_last); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL reset_done: got %b expected 1", done); end
    n_checks++; if (stall !== 1'b0 || dbg_state !== 1'b0) begin n_errors++; $display("FAIL reset_stall_state: got stall=%b state=%b expected 0/0", stall, dbg_state); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_q.delete();
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd11);
    exp_q.push_back(16'd12);
    prim_if.prim_ready = 1'b1;
    start_prim[0] = 16'd10;
    num_prim[0]   = 4'd3;
    @(negedge clk);
    clear_lanes();
    n_checks++; if (prim_if.prim_valid !== 1'b0) begin n_errors++; $display("FAIL basic_latency: valid=%b expected 0 one edge after sampling", prim_if.prim_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_idx = exp_q.pop_front();
      n_checks++;
      if (prim_if.prim_valid !== 1'b1 || prim_if.prim_index !== exp_idx || prim_if.prim_last !== (i == 2)) begin
        n_errors++;
        $display("FAIL basic_beat%0d: got v=%b idx=%0d last=%b expected v=1 idx=%0d last=%b",
                 i, prim_if.prim_valid, prim_if.prim_index, prim_if.prim_last, exp_idx, (i == 2));
      end
    end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_busy: got %b expected 0", done); end
    @(negedge clk);
    n_checks++; if (prim_if.prim_valid !== 1'b0) begin n_errors++; $display("FAIL basic_end_valid: got %b expected 0", prim_if.prim_valid); end
    bvh_finished = 1'b1;
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL basic_done: got %b expected 1", done); end
    bvh_finished = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_lanes();
    logic [15:0] idx_tab  [3] = '{16'd5, 16'd6, 16'd20};
    logic        last_tab [3] = '{1'b0, 1'b1, 1'b1};
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(idx_tab[i]);
    prim_if.prim_ready = 1'b1;
    start_prim[0] = 16'd5;  num_prim[0] = 4'd2;
    start_prim[1] = 16'd20; num_prim[1] = 4'd1;
    @(negedge clk);
    clear_lanes();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_idx = exp_q.pop_front();
      n_checks++;
      if (prim_if.prim_valid !== 1'b1 || prim_if.prim_index !== exp_idx || prim_if.prim_last !== last_tab[i]) begin
        n_errors++;
        $display("FAIL two_lanes_beat%0d: got v=%b idx=%0d last=%b expected v=1 idx=%0d last=%b",
                 i, prim_if.prim_valid, prim_if.prim_index, prim_if.prim_last, exp_idx, last_tab[i]);
      end
    end
    @(negedge clk);
    n_checks++; if (prim_if.prim_valid !== 1'b0) begin n_errors++; $display("FAIL two_lanes_end: valid=%b expected 0", prim_if.prim_valid); end
  endtask

  task automatic test_backpressure();
    logic        rdy_tab  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] idx_tab  [5] = '{16'd7, 16'd7, 16'd7, 16'd8, 16'd8};
    logic        last_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    prim_if.prim_ready = 1'b0;
    start_prim[0] = 16'd7; num_prim[0] = 4'd2;
    @(negedge clk);
    clear_lanes();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (prim_if.prim_valid !== 1'b1 || prim_if.prim_index !== idx_tab[i] || prim_if.prim_last !== last_tab[i]) begin
        n_errors++;
        $display("FAIL backpressure_cyc%0d: got v=%b idx=%0d last=%b expected v=1 idx=%0d last=%b",
                 i, prim_if.prim_valid, prim_if.prim_index, prim_if.prim_last, idx_tab[i], last_tab[i]);
      end
      prim_if.prim_ready = rdy_tab[i];
      @(negedge clk);
    end
    n_checks++; if (prim_if.prim_valid !== 1'b0) begin n_errors++; $display("FAIL backpressure_end: valid=%b expected 0", prim_if.prim_valid); end
    prim_if.prim_ready = 1'b1;
  endtask

  task automatic test_wrap();
    prim_if.prim_ready = 1'b1;
    start_prim[0] = 16'hFFFF; num_prim[0] = 4'd2;
    @(negedge clk);
    clear_lanes();
    @(negedge clk);
    n_checks++; if (prim_if.prim_valid !== 1'b1 || prim_if.prim_index !== 16'hFFFF || prim_if.prim_last !== 1'b0) begin n_errors++; $display("FAIL wrap_first: got v=%b idx=%h last=%b expected v=1 idx=ffff last=0", prim_if.prim_valid, prim_if.prim_index, prim_if.prim_last); end
    @(negedge clk);
    n_checks++; if (prim_if.prim_valid !== 1'b1 || prim_if.prim_index !== 16'h0000 || prim_if.prim_last !== 1'b1) begin n_errors++; $display("FAIL wrap_second: got v=%b idx=%h last=%b expected v=1 idx=0000 last=1", prim_if.prim_valid, prim_if.prim_index, prim_if.prim_last); end
    @(negedge clk);
  endtask

  task automatic test_lane1_only();
    prim_if.prim_ready = 1'b1;
    start_prim[0] = 16'd77; num_prim[0] = 4'd0;
    start_prim[1] = 16'd90; num_prim[1] = 4'd1;
    @(negedge clk);
    clear_lanes();
    @(negedge clk);
    n_checks++; if (prim_if.prim_valid !== 1'b1 || prim_if.prim_index !== 16'd90 || prim_if.prim_last !== 1'b1) begin n_errors++; $display("FAIL lane1_only: got v=%b idx=%0d last=%b expected v=1 idx=90 last=1", prim_if.prim_valid, prim_if.prim_index, prim_if.prim_last); end
    @(negedge clk);
    n_checks++; if (prim_if.prim_valid !== 1'b0) begin n_errors++; $display("FAIL lane1_only_end: valid=%b expected 0 (zero-count lane must be ignored)", prim_if.prim_valid); end
  endtask

  task automatic test_overflow();
    exp_q.delete();
    for (int r = 1; r <= 5; r++) begin
      exp_q.push_back(16'(r * 100));
      exp_q.push_back(16'(r * 100 + 1));
    end
    prim_if.prim_ready = 1'b0;
    start_prim[0] = 16'd100; num_prim[0] = 4'd2;
    start_prim[1] = 16'd200; num_prim[1] = 4'd2;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0 || overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_cycle1: got stall=%b ovf=%b expected 0/0", stall, overflow); end
    start_prim[0] = 16'd300; num_prim[0] = 4'd2;
    start_prim[1] = 16'd400; num_prim[1] = 4'd2;
    @(negedge clk);
    n_checks++; if (stall !== 1'b1 || overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_cycle2: got stall=%b ovf=%b expected 1/0", stall, overflow); end
    start_prim[0] = 16'd500; num_prim[0] = 4'd2;
    start_prim[1] = 16'd600; num_prim[1] = 4'd2;
    @(negedge clk);
    clear_lanes();
    n_checks++; if (stall !== 1'b1 || overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_cycle3: got stall=%b ovf=%b expected 1/1", stall, overflow); end
    prim_if.prim_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_idx = exp_q.pop_front();
      n_checks++;
      if (prim_if.prim_valid !== 1'b1 || prim_if.prim_index !== exp_idx || prim_if.prim_last !== (i % 2 == 1)) begin
        n_errors++;
        $display("FAIL ovf_drain%0d: got v=%b idx=%0d last=%b expected v=1 idx=%0d last=%b",
                 i, prim_if.prim_valid, prim_if.prim_index, prim_if.prim_last, exp_idx, (i % 2 == 1));
      end
      @(negedge clk);
    end
    n_checks++; if (prim_if.prim_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_dropped: valid=%b idx=%0d expected no further index", prim_if.prim_valid, prim_if.prim_index); end
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_restart();
    prim_if.prim_ready = 1'b0;
    start_prim[0] = 16'd40; num_prim[0] = 4'd3;
    start_prim[1] = 16'd50; num_prim[1] = 4'd2;
    @(negedge clk);
    clear_lanes();
    start_prim[0] = 16'd60; num_prim[0] = 4'd1;
    @(negedge clk);
    n_checks++; if (prim_if.prim_valid !== 1'b1 || prim_if.prim_index !== 16'd40 || stall !== 1'b0) begin n_errors++; $display("FAIL restart_pre: got v=%b idx=%0d stall=%b expected v=1 idx=40 stall=0", prim_if.prim_valid, prim_if.prim_index, stall); end
    restart_strobe = 1'b1;
    start_prim[0] = 16'd70; num_prim[0] = 4'd1;
    @(negedge clk);
    restart_strobe = 1'b0;
    clear_lanes();
    n_checks++; if (prim_if.prim_valid !== 1'b0 || overflow !== 1'b0 || dbg_state !== 1'b0) begin n_errors++; $display("FAIL restart_flush: got v=%b ovf=%b state=%b expected 0/0/0", prim_if.prim_valid, overflow, dbg_state); end
    prim_if.prim_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (prim_if.prim_valid !== 1'b0) begin n_errors++; $display("FAIL restart_quiet%0d: valid=%b idx=%0d expected no index", i, prim_if.prim_valid, prim_if.prim_index); end
    end
  endtask

  task automatic test_reset_mid_emit();
    prim_if.prim_ready = 1'b0;
    start_prim[0] = 16'd80; num_prim[0] = 4'd3;
    @(negedge clk);
    clear_lanes();
    @(negedge clk);
    n_checks++; if (prim_if.prim_valid !== 1'b1 || prim_if.prim_index !== 16'd80) begin n_errors++; $display("FAIL rst_mid_pre: got v=%b idx=%0d expected v=1 idx=80", prim_if.prim_valid, prim_if.prim_index); end
    resetn = 1'b0;
    #1;
    n_checks++; if (prim_if.prim_valid !== 1'b0 || prim_if.prim_index !== 16'h0000 || done !== 1'b1) begin n_errors++; $display("FAIL rst_mid_async: got v=%b idx=%0d done=%b expected 0/0/1", prim_if.prim_valid, prim_if.prim_index, done); end
    @(negedge clk);
    resetn = 1'b1;
    prim_if.prim_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (prim_if.prim_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_abandon%0d: valid=%b expected 0", i, prim_if.prim_valid); end
    end
  endtask

  // Test sequence and final report.
  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_two_lanes();
    test_backpressure();
    test_wrap();
    test_lane1_only();
    test_overflow();
    test_restart();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bvh_prim_dispatcher.md
BVH_PRIM_DISPATCHER -- requirements
Module: bvh_prim_dispatcher

Interface
REQ-001 SHALL have parameter IDX_W, default 16, primitive index width.
REQ-002 SHALL have parameter CNT_W, default 4, primitive count width.
REQ-003 SHALL have parameter DEPTH, default 4, range FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port restart_strobe  input  1  synchronous flush, same pulse the BVH traversal unit receives.
REQ-007 SHALL have port start_prim[2]  input  IDX_W each  leaf range start, lanes 0/1, from BVH traversal unit.
REQ-008 SHALL have port num_prim[2]  input  CNT_W each  leaf range count; 0 = lane empty.
REQ-009 SHALL have port bvh_finished  input  1  traversal-complete flag from BVH traversal unit.
REQ-010 SHALL have port stall  output  1  advisory: FIFO free slots < 2.
REQ-011 SHALL have port prim_valid  output  1  prim_index valid.
REQ-012 SHALL have port prim_index  output  IDX_W  primitive to test.
REQ-013 SHALL have port prim_last  output  1  final primitive of current range.
REQ-014 SHALL have port prim_ready  input  1  consumer accepts; transfer = prim_valid & prim_ready.
REQ-015 SHALL have port overflow  output  1  sticky: range dropped for lack of space.
REQ-016 SHALL have port done  output  1  traversal finished and all primitives dispatched.

Function
REQ-017 SHALL enqueue each lane with num_prim != 0 every cycle, lane 0 before lane 1; zero-count lanes ignored.
REQ-018 SHALL, when free slots insufficient, enqueue lane 0 if one slot free, drop the rest, set overflow.
REQ-019 SHALL support simultaneous enqueue (up to 2) and dequeue (1) in one cycle; occupancy = count + pushes - pop.
REQ-020 SHALL drive stall combinationally = (DEPTH - count) < 2.
REQ-021 SHALL implement FSM IDLE/EMIT; IDLE: FIFO non-empty -> pop head, cur<=start, rem<=num, go EMIT.
REQ-022 SHALL in EMIT drive prim_valid=1, prim_index=cur, prim_last=(rem==1), all registered.
REQ-023 SHALL hold prim_index/prim_last stable while prim_valid & !prim_ready.
REQ-024 SHALL on transfer with rem>1: cur<=cur+1 mod 2^IDX_W, rem<=rem-1.
REQ-025 SHALL on transfer with rem==1: pop next range back-to-back if FIFO non-empty (no bubble), else go IDLE, prim_valid=0.
REQ-026 SHALL give latency: range sampled at edge k -> prim_valid high after edge k+1 when IDLE and FIFO empty.
REQ-027 SHALL drive done registered = bvh_finished & FIFO empty & IDLE & no push this cycle.
REQ-028 SHALL on restart_strobe (priority over all): empty FIFO, go IDLE, prim_valid=0, overflow=0, discard same-cycle lanes.
REQ-029 SHALL never emit when rem==0; a range with num=1 emits one index with prim_last=1.

Reset
REQ-030 SHALL on resetn low: FIFO empty, IDLE, prim_valid=0, prim_index=0, prim_last=0, overflow=0, done=1.
REQ-031 SHALL resume normal operation on first rising edge after resetn deasserts; reset mid-EMIT abandons range.

Verification
REQ-032 SHALL test: lane0=(10,3), ready=1 -> indices 10,11,12 on consecutive cycles, prim_last on 12, done=1 once bvh_finished=1.
REQ-033 SHALL test: same cycle lane0=(5,2), lane1=(20,1) -> 5,6,20 back-to-back, prim_last on 6 and 20.
REQ-034 SHALL test: (7,2) with prim_ready 0,0,1,0,1 -> index 7 held 3 cycles, then 8 held until accepted.
REQ-035 SHALL test: (0xFFFF,2) -> 0xFFFF then 0x0000.
REQ-036 SHALL test: ready=0, three cycles of two ranges, DEPTH=4 -> stall=1 after 2nd cycle (first range popped, count 3), overflow=1 after 3rd, no index from dropped range emitted.
REQ-037 SHALL test: restart_strobe during EMIT with 2 queued -> prim_valid=0 next cycle, no further indices, overflow=0.
